rc5_param_core: RTL

Parametrised RC5-W/R/B engine and the successor to the fixed RC5-32/12/16 cipher DUT. It holds the key schedule in internal S and L arrays and runs key expansion on command. It encrypts or decrypts one two-word block at a time, with the mode selected per block. Blocks enter and leave through valid/ready handshakes, so the core can sit directly behind a host or DMA stream stage.

---
 rtl/rc5_param_core.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rc5_param_core.sv
// Parametrised RC5-W/R/B engine: on-chip key expansion into S/L arrays,
// then one two-word block per handshake, one full round per clock.
module rc5_param_core #(
  parameter  int W  = 32,
  parameter  int R  = 12,
  parameter  int B  = 16,
  localparam int AW = (B > 1) ? $clog2(B) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_we,
  input  logic [AW-1:0] key_addr,
  input  logic [7:0]    key_byte,
  input  logic          key_start,
  output logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b
);

  localparam int U  = W / 8;
  localparam int C  = (B + U - 1) / U;
  localparam int T  = 2 * (R + 1);
  localparam int N  = 3 * ((T > C) ? T : C);
  localparam int LW = $clog2(W);
  localparam int IW = $clog2(T);
  localparam int JW = (C > 1) ? $clog2(C) : 1;
  localparam int NW = $clog2(N);
  // k never exceeds R < T/2, so it fits one bit narrower than the S index
  localparam int KW = IW - 1;

  localparam logic [63:0] PW64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                 (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                             64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] QW64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                 (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                             64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] PW = PW64[W-1:0];
  localparam logic [W-1:0] QW = QW64[W-1:0];

  typedef enum logic [2:0] {IDLE, SINIT, MIX, READY, RUN, HOLD} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_s [T];
  logic [W-1:0]    r_l [C];
  logic [W-1:0]    r_a, r_b;
  logic [IW-1:0]   r_i;
  logic [JW-1:0]   r_j;
  logic [NW-1:0]   r_cnt;
  logic [KW-1:0]   r_k;
  logic            r_mode;

  logic [W-1:0]    w_mix_a, w_mix_ab, w_mix_b;
  logic [W-1:0]    w_ea, w_eb, w_da, w_db;
  logic [IW-1:0]   w_ie, w_io;
  logic            w_last;
  logic            w_accept;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] s);
    return (x << s) | (x >> (W - int'(s)));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] s);
    return (x >> s) | (x << (W - int'(s)));
  endfunction

  assign w_ie     = {r_k, 1'b0};
  assign w_io     = {r_k, 1'b1};
  assign w_last   = r_mode ? (r_k == KW'(1)) : (r_k == KW'(R));
  // a key_start in READY wins over a waiting block, so in_ready steps aside
  assign w_accept = (r_state == READY) && !key_start && in_valid;

  // One key-mix step and one enc/dec round, evaluated from current state
  always_comb begin
    w_mix_a  = rotl(r_s[r_i] + r_a + r_b, LW'(3));
    w_mix_ab = w_mix_a + r_b;
    w_mix_b  = rotl(r_l[r_j] + w_mix_ab, w_mix_ab[LW-1:0]);
    w_ea     = rotl(r_a ^ r_b, r_b[LW-1:0]) + r_s[w_ie];
    w_eb     = rotl(r_b ^ w_ea, w_ea[LW-1:0]) + r_s[w_io];
    w_db     = rotr(r_b - r_s[w_io], r_a[LW-1:0]) ^ r_a;
    w_da     = rotr(r_a - r_s[w_ie], w_db[LW-1:0]) ^ w_db;
    // final decrypt round also strips the whitening words
    if (r_k == KW'(1)) begin
      w_db = w_db - r_s[1];
      w_da = w_da - r_s[0];
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (key_start) w_next = SINIT;
      SINIT:   if (r_i == IW'(T - 1)) w_next = MIX;
      MIX:     if (r_cnt == NW'(N - 1)) w_next = READY;
      READY:   if (key_start) w_next = SINIT;
               else if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = HOLD;
      HOLD:    if (out_ready) w_next = READY;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Key storage, schedule generation and round datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < T; x++) r_s[x] <= '0;
      for (int x = 0; x < C; x++) r_l[x] <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_cnt  <= '0;
      r_k    <= '0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        IDLE, READY: begin
          for (int c = 0; c < C; c++)
            for (int u = 0; u < U; u++)
              if (key_we && (c * U + u < B) && (int'(key_addr) == c * U + u))
                r_l[c][8*u +: 8] <= key_byte;
          if (key_start) r_i <= '0;
          if (w_accept) begin
            r_mode <= in_mode;
            r_a    <= in_mode ? in_a : in_a + r_s[0];
            r_b    <= in_mode ? in_b : in_b + r_s[1];
            r_k    <= in_mode ? KW'(R) : KW'(1);
          end
        end
        SINIT: begin
          r_s[r_i] <= (r_i == '0) ? PW : r_s[r_i - 1'b1] + QW;
          if (r_i == IW'(T - 1)) begin
            r_i   <= '0;
            r_j   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        MIX: begin
          r_s[r_i] <= w_mix_a;
          r_l[r_j] <= w_mix_b;
          r_a      <= w_mix_a;
          r_b      <= w_mix_b;
          r_i      <= (r_i == IW'(T - 1)) ? '0 : r_i + 1'b1;
          r_j      <= (r_j == JW'(C - 1)) ? '0 : r_j + 1'b1;
          r_cnt    <= r_cnt + 1'b1;
        end
        RUN: begin
          r_a <= r_mode ? w_da : w_ea;
          r_b <= r_mode ? w_db : w_eb;
          r_k <= r_mode ? r_k - 1'b1 : r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status and result outputs; result words are zero outside HOLD
  always_comb begin
    key_ready = (r_state == READY) || (r_state == RUN) || (r_state == HOLD);
    in_ready  = (r_state == READY) && !key_start;
    out_valid = (r_state == HOLD);
    out_a     = (r_state == HOLD) ? r_a : '0;
    out_b     = (r_state == HOLD) ? r_b : '0;
  end

endmodule
